// File: rtl/bus_arbiter_8_pkg.sv
// Shared definitions for the 8-source round-robin result-bus arbiter.
// Latency: none (types and constants only).
// Backpressure: n/a.
package bus_arbiter_8_pkg;

  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot decode of a source index.
  function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_SRC-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bmux_8.sv
// 8:1 word mux selecting one of eight sources onto the result bus.
// Latency: combinational.
// Backpressure: none; pure select.
//
// Ports: A..H source words 0..7, s select, r selected word.
module bmux_8 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    case (s)
      3'd0:    r = A;
      3'd1:    r = B;
      3'd2:    r = C;
      3'd3:    r = D;
      3'd4:    r = E;
      3'd5:    r = F;
      3'd6:    r = G;
      default: r = H;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_8_rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping 7->0.
// Latency: combinational.
// Backpressure: none; 'any' reports whether a pick exists.
//
// Ports: req request vector, last previous winner, any some request set,
//        pick chosen index (equals last when nothing is requested).
module rr_pick_8
  import bus_arbiter_8_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   pick
);

  logic [SEL_W-1:0] idx;

  // Walk the scan order backwards so the nearest candidate after 'last'
  // is the final one written. k=8 lands on 'last' itself.
  always_comb begin
    any  = |req;
    pick = last;
    idx  = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter sharing one result bus among 8 sources, with grant timeout.
// Latency: 1 cycle from req to out_valid when idle; back-to-back grants with no bubble.
// Backpressure: holds the grant while out_ready=0; aborts after TIMEOUT stalled cycles (0 = never).
//
// Ports: clk, reset (async, active-high); req[7:0]; A..H source words;
//        out_data/out_valid/out_ready result handshake; ack[7:0] transfer pulse;
//        grant_sel current mux select; timeout_err abort pulse.
module bus_arbiter_8
  import bus_arbiter_8_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   E,
  input  logic [WIDTH-1:0]   F,
  input  logic [WIDTH-1:0]   G,
  input  logic [WIDTH-1:0]   H,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_SRC-1:0] ack,
  output logic [SEL_W-1:0]   grant_sel,
  output logic               timeout_err
);

  localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit         TO_EN   = (TIMEOUT != 0);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   last, last_nxt;
  logic [SEL_W-1:0]   grant_sel_nxt;
  logic [7:0]         wait_cnt, wait_cnt_nxt;

  logic [NUM_SRC-1:0] sel_oh;
  logic               sel_req;
  logic [NUM_SRC-1:0] pick_req;
  logic [SEL_W-1:0]   pick_base;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               xfer;
  logic               timeout_hit;

  assign sel_oh      = sel_onehot(grant_sel);
  assign sel_req     = req[grant_sel];
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  // While granted, the next winner is scanned from the current grant with
  // the current grant masked out, so a transfer never re-picks itself.
  assign pick_req  = (state == GRANT) ? (req & ~sel_oh) : req;
  assign pick_base = (state == GRANT) ? grant_sel : last;

  rr_pick_8 u_pick (
    .req  (pick_req),
    .last (pick_base),
    .any  (pick_any),
    .pick (pick_idx)
  );

  bmux_8 #(.WIDTH(WIDTH)) u_mux (
    .A (A), .B (B), .C (C), .D (D),
    .E (E), .F (F), .G (G), .H (H),
    .s (grant_sel),
    .r (out_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= SEL_W'(NUM_SRC - 1);
      grant_sel <= SEL_W'(NUM_SRC - 1);
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      grant_sel <= grant_sel_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    grant_sel_nxt = grant_sel;
    wait_cnt_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_sel_nxt = pick_idx;
          state_nxt     = GRANT;
          wait_cnt_nxt  = '0;
        end
      end
      GRANT: begin
        if (!sel_req) begin
          // Source withdrew its request: drop the grant without a transfer.
          last_nxt  = grant_sel;
          state_nxt = IDLE;
        end else if (xfer) begin
          last_nxt = grant_sel;
          if (pick_any) begin
            grant_sel_nxt = pick_idx;
            wait_cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
          if (timeout_hit) begin
            last_nxt  = grant_sel;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. A transfer takes precedence over a timeout in the same
  // cycle because timeout_err requires out_ready=0.
  always_comb begin
    out_valid   = (state == GRANT) && sel_req;
    xfer        = out_valid && out_ready;
    ack         = xfer ? sel_oh : '0;
    timeout_err = out_valid && !out_ready && timeout_hit;
  end

endmodule
